// File: rtl/agc_out_sink.sv
`default_nettype none
// ============================================================================
// Module      : agc_out_sink
// Description : Rounds/saturates AGC I/Q output, buffers it in a FIFO for a
//               valid/ready stream, and keeps watchdog and drop/sat statistics.
// Revision    : 1.0
// ============================================================================
module agc_out_sink #(
    parameter int W_IN_MODULE = 26,
    parameter int W_OUT       = 16,
    parameter int SHIFT       = 10,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_chans_valid,
    input  logic                          Valid_Out,
    input  logic [W_IN_MODULE-1:0]        OutputI,
    input  logic [W_IN_MODULE-1:0]        OutputQ,
    output logic [W_OUT-1:0]              m_chans_dataI,
    output logic [W_OUT-1:0]              m_chans_dataQ,
    output logic                          m_chans_valid,
    input  logic                          m_chans_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   sat_count,
    output logic [15:0]                   drop_count,
    output logic                          timeout_flag,
    input  logic                          clear_stats
);

    localparam int c_addr_w  = $clog2(FIFO_DEPTH);
    localparam int c_level_w = c_addr_w + 1;
    localparam int c_ext_w   = W_IN_MODULE + 1;
    localparam int c_cnt_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic signed [c_ext_w-1:0] c_half = c_ext_w'(longint'(1) << (SHIFT - 1));
    localparam logic signed [c_ext_w-1:0] c_max  = c_ext_w'((longint'(1) << (W_OUT - 1)) - 1);
    localparam logic signed [c_ext_w-1:0] c_min  = ~c_max;

    localparam logic [0:0] c_wd_idle = 1'b0;
    localparam logic [0:0] c_wd_wait = 1'b1;

    // Returns {saturated, value}; the extra sign bit keeps the rounding add from overflowing.
    function automatic logic [W_OUT:0] fmt_sample(input logic [W_IN_MODULE-1:0] x);
        logic signed [c_ext_w-1:0] sum;
        logic signed [c_ext_w-1:0] shr;
        sum = $signed({x[W_IN_MODULE-1], x}) + c_half;
        shr = sum >>> SHIFT;
        if (shr > c_max) begin
            fmt_sample = {1'b1, c_max[W_OUT-1:0]};
        end else if (shr < c_min) begin
            fmt_sample = {1'b1, c_min[W_OUT-1:0]};
        end else begin
            fmt_sample = {1'b0, shr[W_OUT-1:0]};
        end
    endfunction

    logic [W_OUT:0]       w_fmt_i;
    logic [W_OUT:0]       w_fmt_q;
    logic                 r_stage_valid;
    logic                 r_stage_sat;
    logic [W_OUT-1:0]     r_stage_i;
    logic [W_OUT-1:0]     r_stage_q;

    logic [W_OUT-1:0]     r_mem_i [FIFO_DEPTH];
    logic [W_OUT-1:0]     r_mem_q [FIFO_DEPTH];
    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [c_level_w-1:0] r_level;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;

    logic [15:0]          r_sat_count;
    logic [15:0]          r_drop_count;
    logic                 r_timeout_flag;

    logic [0:0]           r_wd_state;
    logic [0:0]           w_wd_state_nxt;
    logic [c_cnt_w-1:0]   r_wd_cnt;
    logic [c_cnt_w-1:0]   w_wd_cnt_nxt;
    logic                 w_wd_expire;

    assign w_fmt_i = fmt_sample(OutputI);
    assign w_fmt_q = fmt_sample(OutputQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stage_valid <= 1'b0;
            r_stage_sat   <= 1'b0;
            r_stage_i     <= '0;
            r_stage_q     <= '0;
        end else begin
            r_stage_valid <= Valid_Out;
            if (Valid_Out) begin
                r_stage_i   <= w_fmt_i[W_OUT-1:0];
                r_stage_q   <= w_fmt_q[W_OUT-1:0];
                r_stage_sat <= w_fmt_i[W_OUT] | w_fmt_q[W_OUT];
            end
        end
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_level_w'(FIFO_DEPTH));
    assign w_pop   = !w_empty && m_chans_ready;
    assign w_push  = r_stage_valid && (!w_full || w_pop);
    assign w_drop  = r_stage_valid && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_i[r_wr_ptr] <= r_stage_i;
            r_mem_q[r_wr_ptr] <= r_stage_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_level_w'(1);
                2'b01:   r_level <= r_level - c_level_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign m_chans_valid = !w_empty;
    assign m_chans_dataI = w_empty ? '0 : r_mem_i[r_rd_ptr];
    assign m_chans_dataQ = w_empty ? '0 : r_mem_q[r_rd_ptr];
    assign fifo_level    = r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_count  <= '0;
            r_drop_count <= '0;
        end else if (clear_stats) begin
            r_sat_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (r_stage_valid && r_stage_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wd_state     <= c_wd_idle;
            r_wd_cnt       <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_wd_state <= w_wd_state_nxt;
            r_wd_cnt   <= w_wd_cnt_nxt;
            if (clear_stats) begin
                r_timeout_flag <= 1'b0;
            end else if (w_wd_expire) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    // A fresh input strobe always restarts the window, even alongside an output strobe.
    always_comb begin
        w_wd_state_nxt = r_wd_state;
        w_wd_cnt_nxt   = r_wd_cnt;
        w_wd_expire    = 1'b0;
        case (r_wd_state)
            c_wd_idle: begin
                if (s_chans_valid) begin
                    w_wd_state_nxt = c_wd_wait;
                    w_wd_cnt_nxt   = '0;
                end
            end
            c_wd_wait: begin
                if (s_chans_valid) begin
                    w_wd_cnt_nxt = '0;
                end else if (Valid_Out) begin
                    w_wd_state_nxt = c_wd_idle;
                end else if (r_wd_cnt == c_cnt_w'(TIMEOUT - 1)) begin
                    w_wd_expire    = 1'b1;
                    w_wd_state_nxt = c_wd_idle;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_wd_state_nxt = c_wd_idle;
            end
        endcase
    end

    assign timeout_flag = r_timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_agc_out_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_agc_out_sink
// Description : Scoreboard bench for agc_out_sink formatting, FIFO and watchdog.
// Revision    : 1.0
// ============================================================================
module tb_agc_out_sink;

    localparam int W_IN    = 26;
    localparam int W_OUT   = 16;
    localparam int SHIFT   = 10;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_chans_valid = 1'b0;
    logic              Valid_Out = 1'b0;
    logic [W_IN-1:0]   OutputI = '0;
    logic [W_IN-1:0]   OutputQ = '0;
    logic [W_OUT-1:0]  m_chans_dataI;
    logic [W_OUT-1:0]  m_chans_dataQ;
    logic              m_chans_valid;
    logic              m_chans_ready = 1'b0;
    logic [3:0]        fifo_level;
    logic [15:0]       sat_count;
    logic [15:0]       drop_count;
    logic              timeout_flag;
    logic              clear_stats = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_sat  = 0;
    int exp_drop = 0;
    int sb_i[$];
    int sb_q[$];
    int mon_ei;
    int mon_eq;

    always #5 clk = ~clk;

    agc_out_sink #(
        .W_IN_MODULE (W_IN),
        .W_OUT       (W_OUT),
        .SHIFT       (SHIFT),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_chans_valid (s_chans_valid),
        .Valid_Out     (Valid_Out),
        .OutputI       (OutputI),
        .OutputQ       (OutputQ),
        .m_chans_dataI (m_chans_dataI),
        .m_chans_dataQ (m_chans_dataQ),
        .m_chans_valid (m_chans_valid),
        .m_chans_ready (m_chans_ready),
        .fifo_level    (fifo_level),
        .sat_count     (sat_count),
        .drop_count    (drop_count),
        .timeout_flag  (timeout_flag),
        .clear_stats   (clear_stats)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Round half-up by floor division, then clamp to the output range.
    function automatic int fmt_model(input int x, output bit sat);
        longint t;
        longint d;
        longint q;
        longint hi;
        longint lo;
        d  = longint'(1) << SHIFT;
        t  = longint'(x) + (d / 2);
        q  = t / d;
        if ((t < 0) && ((t % d) != 0)) q = q - 1;
        hi = (longint'(1) << (W_OUT - 1)) - 1;
        lo = -(longint'(1) << (W_OUT - 1));
        sat = 1'b0;
        if (q > hi) begin q = hi; sat = 1'b1; end
        if (q < lo) begin q = lo; sat = 1'b1; end
        return int'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int q, input bit drop);
        int ei;
        int eq;
        bit si;
        bit sq;
        ei = fmt_model(i, si);
        eq = fmt_model(q, sq);
        if (si || sq) exp_sat++;
        if (drop) begin
            exp_drop++;
        end else begin
            sb_i.push_back(ei);
            sb_q.push_back(eq);
        end
        OutputI   = W_IN'(i);
        OutputQ   = W_IN'(q);
        Valid_Out = 1'b1;
        tick();
        Valid_Out = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        tick();
        tick();
        while ((m_chans_valid || (fifo_level != 4'd0)) && (n < 40)) begin
            tick();
            n++;
        end
        chk({tag, "_level"}, int'(fifo_level), 0);
        chk({tag, "_valid"}, int'(m_chans_valid), 0);
        chk({tag, "_sb_left"}, sb_i.size(), 0);
    endtask

    task automatic do_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        exp_sat  = 0;
        exp_drop = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && m_chans_valid && m_chans_ready) begin
            if (sb_i.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                mon_ei = sb_i.pop_front();
                mon_eq = sb_q.pop_front();
                chk("out_I", int'($signed(m_chans_dataI)), mon_ei);
                chk("out_Q", int'($signed(m_chans_dataQ)), mon_eq);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int r1;
        int r2;
        tick();
        tick();
        chk("rst_valid", int'(m_chans_valid), 0);
        chk("rst_dataI", int'(m_chans_dataI), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_sat", int'(sat_count), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_flag", int'(timeout_flag), 0);
        rst_n = 1'b1;
        tick();

        // Rounding and two-cycle latency
        m_chans_ready = 1'b1;
        send(1536, -1536, 1'b0);
        chk("lat_n1_valid", int'(m_chans_valid), 0);
        tick();
        chk("lat_n2_valid", int'(m_chans_valid), 1);
        chk("round_I", int'($signed(m_chans_dataI)), 2);
        chk("round_Q", int'($signed(m_chans_dataQ)), -1);
        chk("round_sat", int'(sat_count), 0);

        // Saturation of I only
        send(33554431, -33554432, 1'b0);
        tick();
        chk("sat_I", int'($signed(m_chans_dataI)), 32767);
        chk("sat_Q", int'($signed(m_chans_dataQ)), -32768);
        chk("sat_count1", int'(sat_count), 1);

        // Random samples, back to back
        for (int k = 0; k < 8; k++) begin
            r1 = int'($urandom) >>> 6;
            r2 = int'($urandom) >>> 6;
            send(r1, r2, 1'b0);
        end
        wait_drain("rand");
        chk("rand_sat", int'(sat_count), exp_sat);
        chk("rand_drop", int'(drop_count), 0);

        // Backpressure: 10 samples into 8 entries
        do_clear();
        m_chans_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            send(k * 1024 + 100, -(k * 2048), k >= DEPTH);
        end
        tick();
        tick();
        chk("bp_level", int'(fifo_level), 8);
        chk("bp_drop", int'(drop_count), exp_drop);
        chk("bp_drop_abs", int'(drop_count), 2);
        chk("bp_valid", int'(m_chans_valid), 1);
        m_chans_ready = 1'b1;
        wait_drain("bp");

        // Full FIFO with a same-cycle pop must not drop
        m_chans_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            send(k * 512, k * 700, 1'b0);
        end
        send(9000, -9000, 1'b0);
        chk("full_level_pre", int'(fifo_level), 8);
        m_chans_ready = 1'b1;
        tick();
        m_chans_ready = 1'b0;
        chk("full_pop_level", int'(fifo_level), 8);
        chk("full_pop_drop", int'(drop_count), exp_drop);
        m_chans_ready = 1'b1;
        wait_drain("full_pop");

        // Watchdog with regular cadence, then a missing output
        do_clear();
        for (int c = 0; c < 3; c++) begin
            s_chans_valid = 1'b1;
            tick();
            s_chans_valid = 1'b0;
            repeat (19) tick();
            send(c * 1024, c * 1024, 1'b0);
            repeat (19) tick();
        end
        chk("wd_cadence_flag", int'(timeout_flag), 0);
        s_chans_valid = 1'b1;
        tick();
        s_chans_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("wd_63_flag", int'(timeout_flag), 0);
        tick();
        chk("wd_64_flag", int'(timeout_flag), 1);
        do_clear();
        chk("wd_clear_flag", int'(timeout_flag), 0);
        wait_drain("wd");

        // Reset while samples are buffered
        m_chans_ready = 1'b0;
        send(33554431, 0, 1'b0);
        send(1000, 1000, 1'b0);
        send(2000, 2000, 1'b0);
        tick();
        tick();
        chk("mid_level", int'(fifo_level), 3);
        chk("mid_sat", int'(sat_count), exp_sat);
        rst_n = 1'b0;
        sb_i.delete();
        sb_q.delete();
        exp_sat  = 0;
        exp_drop = 0;
        tick();
        rst_n = 1'b1;
        chk("mrst_level", int'(fifo_level), 0);
        chk("mrst_valid", int'(m_chans_valid), 0);
        chk("mrst_sat", int'(sat_count), 0);
        chk("mrst_drop", int'(drop_count), 0);
        chk("mrst_flag", int'(timeout_flag), 0);
        m_chans_ready = 1'b1;
        send(5120, -5120, 1'b0);
        chk("post_n1_valid", int'(m_chans_valid), 0);
        tick();
        chk("post_n2_valid", int'(m_chans_valid), 1);
        chk("post_I", int'($signed(m_chans_dataI)), 5);
        chk("post_Q", int'($signed(m_chans_dataQ)), -5);
        wait_drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
